cla_addsub_pipe: RTL and testbench
==================================

Name: cla_addsub_pipe

Overview:
- Two-stage pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides.
- Stage 1 computes the low half of the result with lookahead carry. Stage 2 computes the high half using the registered low-half carry.
- Used in datapaths where a single-cycle wide CLA misses timing and operands arrive as a stream.

Parameters:
- WIDTH, 8: operand and result width. Must be even and >= 2. Low half = WIDTH/2 bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- a  in  WIDTH  operand A (unsigned or two's complement)
- b  in  WIDTH  operand B
- sub  in  1  0: A+B, 1: A-B
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result this cycle
- result  out  WIDTH  A+B or A-B, modulo 2^WIDTH
- carry_out  out  1  carry from MSB. For sub, 1 means no borrow (A >= B unsigned).
- overflow  out  1  signed two's-complement overflow

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, result=0, carry_out=0, overflow=0. in_ready reads 1 the cycle after reset releases.
- Operand preparation (combinational, stage 1 input):
  - bx = sub ? ~b : b
  - c0 = sub
- Lookahead carries:
  - g = a & bx, p = a ^ bx.
  - Carries for each half are built as flat generate/propagate sum-of-products with carry-in, not rippled.
- Stage 1 register, loaded on in_valid && in_ready:
  - low-half sum
  - low-half carry-out c_lo
  - a_hi, bx_hi
  - a[MSB], bx[MSB]
  - s1_valid=1
- Stage 2 register, loaded on s2_load = s1_valid && (!s2_valid || out_ready):
  - high-half sum using c_lo as carry-in
  - carry_out = carry from bit WIDTH-1
  - overflow = carry into MSB XOR carry out of MSB
  - s2_valid=1
- Handshake and stall:
  - in_ready = !s1_valid || s2_load (combinational; depends on out_ready).
  - s1_valid clears when s2_load fires with no new input. s2_valid clears when out_valid && out_ready fires with no s2_load.
  - out_valid = s2_valid.
  - result, carry_out and overflow hold stable while out_valid && !out_ready.
  - in_valid may not be withdrawn by the producer before acceptance. The block does not check this.
- Latency: a beat accepted in cycle N appears at out_valid in cycle N+2, given out_ready held high. Throughput is 1 beat/cycle.
- Backpressure: with out_ready low, at most 2 beats are held (one per stage). in_ready drops once both stages are full.
- Simultaneous events:
  - Output accept and s2_load in the same cycle: stage 2 takes the new value and out_valid stays 1.
  - Input accept and s1 drain in the same cycle: stage 1 takes the new value.
- Datapath registers only update on their load enables. No X propagation from idle inputs into valid outputs.
- Reset mid-operation: all in-flight beats are discarded. No output beat is produced for them.
- WIDTH=2: each half is a single bit. The same rules apply.

Test Plan:
- WIDTH=8, out_ready=1, single beat a=0x3C, b=0x45, sub=0 -> two cycles later out_valid=1, result=0x81, carry_out=0, overflow=1.
- Subtract a=0x10, b=0x20, sub=1 -> result=0xF0, carry_out=0 (borrow), overflow=0. Then a=0x20, b=0x10 -> result=0x10, carry_out=1.
- Carry across halves: a=0x0F, b=0x01, sub=0 -> result=0x10. Then a=0xFF, b=0x01 -> result=0x00, carry_out=1, overflow=0.
- Back-to-back stream of 16 random beats with out_ready=1 and in_valid=1 -> in_ready stays 1, one result per cycle in order, each matching the reference model (a±b, carry, overflow).
- Backpressure: out_ready=0 while 3 beats are offered -> in_ready goes 0 after 2 accepted, outputs stay stable. Raising out_ready drains both results in order, then the third beat is accepted.
- Reset asserted with both stages full -> out_valid=0 and result=0 immediately (asynchronous). After release, in_ready=1 and no stale beat emerges.

Source files
------------

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor.
// Stage 1 adds the low half with lookahead carries and registers the
// high-half operands; stage 2 finishes the high half from the registered
// low-half carry. Both sides use a valid/ready handshake.
module cla_addsub_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int H = WIDTH / 2;

    // Flat lookahead: each carry c[i+1] is the OR of g[j] & p[i:j+1]
    // over all j, plus p[i:0] & cin. Nothing ripples through c[i].
    function automatic logic [H:0] cla_carries(input logic [H-1:0] g,
                                               input logic [H-1:0] p,
                                               input logic         cin);
        logic [H:0] c;
        logic       term;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < H; i++) begin
            term = cin;
            for (int k = 0; k <= i; k++) term = term & p[k];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) term = term & p[k];
                c[i+1] = c[i+1] | term;
            end
        end
        return c;
    endfunction

    // Stage 1 state
    logic             s1_valid_q, s1_valid_d;
    logic [H-1:0]     s1_sum_lo_q;
    logic             s1_c_lo_q;
    logic [H-1:0]     s1_a_hi_q;
    logic [H-1:0]     s1_bx_hi_q;

    // Stage 2 state
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             overflow_q;

    // Stage 1 combinational datapath
    logic [WIDTH-1:0] bx;
    logic [H-1:0]     g_lo, p_lo, sum_lo;
    logic [H:0]       c_lo_vec;

    // Stage 2 combinational datapath
    logic [H-1:0]     g_hi, p_hi, sum_hi;
    logic [H:0]       c_hi_vec;

    logic s1_load, s2_load;

    // Subtraction is A + ~B + 1: invert B and feed sub in as the carry.
    always_comb begin
        bx       = sub ? ~b : b;
        g_lo     = a[H-1:0] & bx[H-1:0];
        p_lo     = a[H-1:0] ^ bx[H-1:0];
        c_lo_vec = cla_carries(g_lo, p_lo, sub);
        sum_lo   = p_lo ^ c_lo_vec[H-1:0];
    end

    // High half; the MSB is the top bit of the registered high operands,
    // so overflow is carry-into-MSB XOR carry-out-of-MSB.
    always_comb begin
        g_hi     = s1_a_hi_q & s1_bx_hi_q;
        p_hi     = s1_a_hi_q ^ s1_bx_hi_q;
        c_hi_vec = cla_carries(g_hi, p_hi, s1_c_lo_q);
        sum_hi   = p_hi ^ c_hi_vec[H-1:0];
    end

    // Handshake: stage 2 advances when empty or its beat is being taken;
    // stage 1 accepts when empty or draining into stage 2 this cycle.
    always_comb begin
        s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready = !s1_valid_q || s2_load;
        s1_load  = in_valid && in_ready;

        s1_valid_d = s1_valid_q;
        if (s1_load)
            s1_valid_d = 1'b1;
        else if (s2_load)
            s1_valid_d = 1'b0;

        s2_valid_d = s2_valid_q;
        if (s2_load)
            s2_valid_d = 1'b1;
        else if (out_ready)
            s2_valid_d = 1'b0;
    end

    // Valid bits for both stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // Stage 1 datapath register, loaded only on an accepted input beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sum_lo_q <= '0;
            s1_c_lo_q   <= 1'b0;
            s1_a_hi_q   <= '0;
            s1_bx_hi_q  <= '0;
        end else if (s1_load) begin
            s1_sum_lo_q <= sum_lo;
            s1_c_lo_q   <= c_lo_vec[H];
            s1_a_hi_q   <= a[WIDTH-1:H];
            s1_bx_hi_q  <= bx[WIDTH-1:H];
        end
    end

    // Stage 2 datapath register; holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else if (s2_load) begin
            result_q   <= {sum_hi, s1_sum_lo_q};
            carry_q    <= c_hi_vec[H];
            overflow_q <= c_hi_vec[H] ^ c_hi_vec[H-1];
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign carry_out = carry_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe (WIDTH=8) with a plain-arithmetic
// reference model for sum/difference, carry/borrow and signed overflow.
module tb_cla_addsub_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         o;
    } exp_t;

    cla_addsub_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference: integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic msub);
        exp_t   e;
        longint ua, ub, sa, sb, sr, ur;
        ua = longint'(ma);
        ub = longint'(mb);
        sa = (ua >= (64'sd1 << (W-1))) ? ua - (64'sd1 << W) : ua;
        sb = (ub >= (64'sd1 << (W-1))) ? ub - (64'sd1 << W) : ub;
        if (msub) begin
            ur  = ua - ub;
            sr  = sa - sb;
            e.c = (ua >= ub);
        end else begin
            ur  = ua + ub;
            sr  = sa + sb;
            e.c = (ur >= (64'sd1 << W));
        end
        e.r = ur[W-1:0];
        e.o = (sr > (64'sd1 << (W-1)) - 1) || (sr < -(64'sd1 << (W-1)));
        return e;
    endfunction

    // Drive one clock cycle of stimulus and report what the DUT did.
    task automatic run_cycle(input logic iv, input logic ordy,
                             input logic [W-1:0] ia, input logic [W-1:0] ib,
                             input logic isub,
                             output logic acc, output logic dlv, output logic ov,
                             output logic rdy, output logic [W-1:0] r,
                             output logic c, output logic o);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        sub       = isub;
        out_ready = ordy;
        @(negedge clk);
        rdy = in_ready;
        ov  = out_valid;
        acc = iv && in_ready;
        dlv = out_valid && ordy;
        r   = result;
        c   = carry_out;
        o   = overflow;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic acc, dlv, ov, rdy, c, o;
        logic [W-1:0] r;
        n_cmp++;
        if (out_valid !== 1'b0 || result !== '0 || carry_out !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ov=%b r=%h c=%b o=%b, need 0 0 0 0",
                     out_valid, result, carry_out, overflow);
        end
        run_cycle(1'b0, 1'b1, '0, '0, 1'b0, acc, dlv, ov, rdy, r, c, o);
        n_cmp++;
        if (rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b need 1", rdy);
        end
        $display("test_reset: done");
    endtask

    task automatic test_single(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                               input logic tsub, input logic [W-1:0] er,
                               input logic ec, input logic eo);
        logic acc, dlv, ov, rdy, c, o;
        logic [W-1:0] r;
        run_cycle(1'b1, 1'b1, ta, tb_, tsub, acc, dlv, ov, rdy, r, c, o);
        n_cmp++;
        if (acc !== 1'b1) begin
            n_fail++;
            $display("FAIL single_accept: in_ready=%b need 1", rdy);
        end
        run_cycle(1'b0, 1'b1, '0, '0, 1'b0, acc, dlv, ov, rdy, r, c, o);
        n_cmp++;
        if (ov !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: out_valid=%b one cycle after accept, need 0", ov);
        end
        run_cycle(1'b0, 1'b1, '0, '0, 1'b0, acc, dlv, ov, rdy, r, c, o);
        n_cmp++;
        if (ov !== 1'b1 || r !== er || c !== ec || o !== eo) begin
            n_fail++;
            $display("FAIL single_result: a=%h b=%h sub=%b got v=%b r=%h c=%b o=%b need v=1 r=%h c=%b o=%b",
                     ta, tb_, tsub, ov, r, c, o, er, ec, eo);
        end
        $display("single: a=%h b=%h sub=%b -> r=%h c=%b o=%b", ta, tb_, tsub, r, c, o);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va[16], vb[16];
        logic         vs[16];
        exp_t         e;
        int           delivered = 0;
        int           cyc = 0;
        logic acc, dlv, ov, rdy, c, o;
        logic [W-1:0] r;
        for (int i = 0; i < 16; i++) begin
            va[i] = W'($urandom);
            vb[i] = W'($urandom);
            vs[i] = 1'($urandom);
        end
        while (delivered < 16 && cyc < 40) begin
            if (cyc < 16)
                run_cycle(1'b1, 1'b1, va[cyc], vb[cyc], vs[cyc], acc, dlv, ov, rdy, r, c, o);
            else
                run_cycle(1'b0, 1'b1, '0, '0, 1'b0, acc, dlv, ov, rdy, r, c, o);
            if (cyc < 16) begin
                n_cmp++;
                if (rdy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_in_ready: cycle %0d in_ready=%b need 1", cyc, rdy);
                end
            end
            if (dlv) begin
                e = model(va[delivered], vb[delivered], vs[delivered]);
                n_cmp++;
                if (cyc != delivered + 2 || r !== e.r || c !== e.c || o !== e.o) begin
                    n_fail++;
                    $display("FAIL b2b_result: beat %0d cycle %0d got r=%h c=%b o=%b need cycle %0d r=%h c=%b o=%b",
                             delivered, cyc, r, c, o, delivered + 2, e.r, e.c, e.o);
                end
                $display("b2b: beat %0d a=%h b=%h sub=%b -> r=%h c=%b o=%b",
                         delivered, va[delivered], vb[delivered], vs[delivered], r, c, o);
                delivered++;
            end
            cyc++;
        end
        n_cmp++;
        if (delivered != 16) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results need 16", delivered);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] va[3], vb[3];
        logic         vs[3];
        exp_t         e0, e;
        int           offered = 0;
        int           delivered = 0;
        int           cyc = 0;
        logic acc, dlv, ov, rdy, c, o, ordy;
        logic [W-1:0] r;
        for (int i = 0; i < 3; i++) begin
            va[i] = W'($urandom);
            vb[i] = W'($urandom);
            vs[i] = 1'($urandom);
        end
        e0 = model(va[0], vb[0], vs[0]);
        while (delivered < 3 && cyc < 20) begin
            ordy = (cyc >= 5);
            if (offered < 3)
                run_cycle(1'b1, ordy, va[offered], vb[offered], vs[offered], acc, dlv, ov, rdy, r, c, o);
            else
                run_cycle(1'b0, ordy, '0, '0, 1'b0, acc, dlv, ov, rdy, r, c, o);
            if (cyc >= 2 && cyc < 5) begin
                n_cmp++;
                if (rdy !== 1'b0 || ov !== 1'b1 || r !== e0.r || c !== e0.c || o !== e0.o) begin
                    n_fail++;
                    $display("FAIL bp_stall: cycle %0d got rdy=%b v=%b r=%h c=%b o=%b need rdy=0 v=1 r=%h c=%b o=%b",
                             cyc, rdy, ov, r, c, o, e0.r, e0.c, e0.o);
                end
            end
            if (acc) offered++;
            if (cyc == 4) begin
                n_cmp++;
                if (offered != 2) begin
                    n_fail++;
                    $display("FAIL bp_accepted: got %0d beats held need 2", offered);
                end
            end
            if (dlv) begin
                e = model(va[delivered], vb[delivered], vs[delivered]);
                n_cmp++;
                if (r !== e.r || c !== e.c || o !== e.o) begin
                    n_fail++;
                    $display("FAIL bp_result: beat %0d got r=%h c=%b o=%b need r=%h c=%b o=%b",
                             delivered, r, c, o, e.r, e.c, e.o);
                end
                $display("bp: beat %0d -> r=%h c=%b o=%b", delivered, r, c, o);
                delivered++;
            end
            cyc++;
        end
        n_cmp++;
        if (delivered != 3) begin
            n_fail++;
            $display("FAIL bp_count: got %0d results need 3", delivered);
        end
    endtask

    task automatic test_reset_mid();
        logic acc, dlv, ov, rdy, c, o;
        logic [W-1:0] r;
        run_cycle(1'b1, 1'b0, 8'hFF, 8'h01, 1'b0, acc, dlv, ov, rdy, r, c, o);
        run_cycle(1'b1, 1'b0, 8'h7F, 8'h7F, 1'b0, acc, dlv, ov, rdy, r, c, o);
        run_cycle(1'b0, 1'b0, '0, '0, 1'b0, acc, dlv, ov, rdy, r, c, o);
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_fill: got v=%b rdy=%b need v=1 rdy=0", out_valid, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || result !== '0 || carry_out !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async_reset: got v=%b r=%h c=%b o=%b need 0 0 0 0",
                     out_valid, result, carry_out, overflow);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_cycle(1'b0, 1'b1, '0, '0, 1'b0, acc, dlv, ov, rdy, r, c, o);
            n_cmp++;
            if (rdy !== 1'b1 || ov !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_no_stale: cycle %0d got rdy=%b v=%b need rdy=1 v=0", i, rdy, ov);
            end
        end
        $display("reset_mid: done");
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        test_reset();
        test_single(8'h3C, 8'h45, 1'b0, 8'h81, 1'b0, 1'b1);
        test_single(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        test_single(8'h20, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0);
        test_single(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        test_single(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        test_single(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        test_back_to_back();
        test_backpressure();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
